// File: rtl/evm_vote_controller.sv
// evm_vote_controller: election state machine with per-candidate tallies, vote lockout and winner scan
// Ports:
//   clk_100MHz, reset_n             system clock and asynchronous active-low reset
//   open_btn, close_btn, result_btn,
//   clear_btn, vote_btn[3:0]        debounced level buttons, acted on at their rising edge
//   state[1:0]                      00 idle, 01 open, 10 closed, 11 result
//   winner[1:0]                     winning candidate index, valid in result
//   vote_count[4:0]                 value shown on the display (0..19)
//   vote_ack, vote_reject           one-cycle outcome pulses for a vote attempt
//   busy                            high during the 4-cycle winner scan
module evm_vote_controller #(
    parameter int NUM_CAND       = 4,
    parameter int MAX_VOTES      = 19,
    parameter int LOCKOUT_CYCLES = 100_000_000
) (
    input  logic                clk_100MHz,
    input  logic                reset_n,
    input  logic                open_btn,
    input  logic                close_btn,
    input  logic                result_btn,
    input  logic                clear_btn,
    input  logic [NUM_CAND-1:0] vote_btn,
    output logic [1:0]          state,
    output logic [1:0]          winner,
    output logic [4:0]          vote_count,
    output logic                vote_ack,
    output logic                vote_reject,
    output logic                busy
);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, OPEN = 2'b01, CLOSED = 2'b10, RESULT = 2'b11} state_t;
    state_t st, st_nx;
    logic open_q, close_q, result_q, clear_q;
    logic open_ev, close_ev, result_ev, clear_ev;
    logic [NUM_CAND-1:0] vote_q, vote_ev;
    logic [4:0] tally [NUM_CAND];
    logic [4:0] total, total_nx, count_nx;
    logic [LW-1:0] lockout;
    logic [1:0] idx, best, best_nx, winner_nx;
    logic accept, reject, start_scan, scan_done, open_clr;
    assign open_ev    = open_btn & ~open_q;
    assign close_ev   = close_btn & ~close_q;
    assign result_ev  = result_btn & ~result_q;
    assign clear_ev   = clear_btn & ~clear_q;
    assign vote_ev    = vote_btn & ~vote_q;
    assign open_clr   = st == IDLE && open_ev;
    // clear wins over a simultaneous result press in CLOSED
    assign start_scan = st == CLOSED && !busy && result_ev && !clear_ev;
    assign scan_done  = busy && idx == 2'd3;
    // strict greater-than keeps ties on the lowest index
    assign best_nx    = tally[idx] > tally[best] ? idx : best;
    assign state      = st;
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) st <= IDLE;
        else          st <= st_nx;
    end
    always_comb begin
        st_nx = st;
        case (st)
            IDLE:   if (open_ev) st_nx = OPEN;
            OPEN:   if (close_ev) st_nx = CLOSED;
            CLOSED: if (scan_done) st_nx = RESULT; else if (!busy && clear_ev) st_nx = IDLE;
            RESULT: if (clear_ev) st_nx = IDLE;
        endcase
    end
    always_comb begin
        accept = 1'b0;
        reject = 1'b0;
        // a vote coinciding with close is dropped without ack or reject
        if (st == OPEN && vote_ev != '0 && !close_ev) begin
            accept = (vote_ev & (vote_ev - NUM_CAND'(1))) == '0 && vote_btn == vote_ev &&
                     lockout == '0 && total < 5'(MAX_VOTES);
            reject = !accept;
        end
        total_nx  = open_clr ? 5'd0 : total + {4'd0, accept};
        winner_nx = st_nx != RESULT ? 2'd0 : st == CLOSED ? best_nx : winner;
        count_nx  = st_nx == IDLE ? 5'd0 : st_nx != RESULT ? total_nx :
                    st == CLOSED ? tally[best_nx] : vote_count;
    end
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            {open_q, close_q, result_q, clear_q} <= '0;
            vote_q      <= '0;
            total       <= '0;
            lockout     <= '0;
            idx         <= '0;
            best        <= '0;
            busy        <= 1'b0;
            winner      <= '0;
            vote_count  <= '0;
            vote_ack    <= 1'b0;
            vote_reject <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
        end else begin
            {open_q, close_q, result_q, clear_q} <= {open_btn, close_btn, result_btn, clear_btn};
            vote_q      <= vote_btn;
            total       <= total_nx;
            lockout     <= open_clr ? '0 : accept ? LW'(LOCKOUT_CYCLES) :
                           lockout != '0 ? lockout - LW'(1) : lockout;
            idx         <= busy ? idx + 2'd1 : 2'd0;
            best        <= start_scan ? 2'd0 : busy ? best_nx : best;
            busy        <= start_scan || (busy && !scan_done);
            winner      <= winner_nx;
            vote_count  <= count_nx;
            vote_ack    <= accept;
            vote_reject <= reject;
            for (int i = 0; i < NUM_CAND; i++)
                if (open_clr) tally[i] <= '0;
                else if (accept && vote_ev[i]) tally[i] <= tally[i] + 5'd1;
        end
    end
endmodule
